// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads bytes at pc, assembles 1..3-byte instructions
// and hands them to the decoder over a valid/ready handshake.
module fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   pc,
  output logic                pcEnable,
  output logic [ADDR_W-1:0]   memAddr,
  output logic                memRead,
  input  logic [DATA_W-1:0]   memData,
  input  logic                memReady,
  input  logic                flush,
  output logic                instrValid,
  input  logic                instrReady,
  output logic [DATA_W-1:0]   opcode,
  output logic [2*DATA_W-1:0] operand,
  output logic [1:0]          instrLen,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    FETCH_OP = 2'd0,
    FETCH_B1 = 2'd1,
    FETCH_B2 = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t state;

  // Handshake: a transfer happens on the rising edge where instrValid and
  // instrReady are both high and flush is low; valid never depends on ready.

  function automatic logic [1:0] decode_len(input logic [DATA_W-1:0] op);
    case (op[DATA_W-1 -: 2])
      2'b00:   return 2'd1;
      2'b01:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  assign memAddr   = pc;
  assign memRead   = reset & ~flush & (state != HOLD);
  // programCounter increments on the same edge the byte is captured.
  assign pcEnable  = memRead & memReady;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= FETCH_OP;
      instrValid <= 1'b0;
      opcode     <= '0;
      operand    <= '0;
      instrLen   <= '0;
    end else if (flush) begin
      state      <= FETCH_OP;
      instrValid <= 1'b0;
      opcode     <= '0;
      operand    <= '0;
      instrLen   <= '0;
    end else begin
      case (state)
        FETCH_OP: begin
          if (memReady) begin
            opcode   <= memData;
            operand  <= '0;
            instrLen <= decode_len(memData);
            if (decode_len(memData) == 2'd1) begin
              state      <= HOLD;
              instrValid <= 1'b1;
            end else begin
              state <= FETCH_B1;
            end
          end
        end
        FETCH_B1: begin
          if (memReady) begin
            operand[DATA_W-1:0] <= memData;
            if (instrLen == 2'd3) begin
              state <= FETCH_B2;
            end else begin
              state      <= HOLD;
              instrValid <= 1'b1;
            end
          end
        end
        FETCH_B2: begin
          if (memReady) begin
            operand[2*DATA_W-1:DATA_W] <= memData;
            state      <= HOLD;
            instrValid <= 1'b1;
          end
        end
        HOLD: begin
          if (instrReady) begin
            state      <= FETCH_OP;
            instrValid <= 1'b0;
          end
        end
        default: begin
          state      <= FETCH_OP;
          instrValid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: models programCounter and program memory, runs a vector
// table, directed corner sequences and a randomized scoreboard run.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] pc = '0;
  logic        pcEnable;
  logic [15:0] memAddr;
  logic        memRead;
  logic [7:0]  memData;
  logic        memReady = 1'b0;
  logic        flush = 1'b0;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic [7:0]  opcode;
  logic [15:0] operand;
  logic [1:0]  instrLen;
  logic [1:0]  dbg_state;

  logic        pc_load = 1'b0;
  logic [15:0] load_pc = '0;
  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pcEnable(pcEnable),
    .memAddr(memAddr), .memRead(memRead), .memData(memData),
    .memReady(memReady), .flush(flush), .instrValid(instrValid),
    .instrReady(instrReady), .opcode(opcode), .operand(operand),
    .instrLen(instrLen), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // programCounter model: load beats increment
  always @(posedge clk) begin
    if (pc_load) pc <= load_pc;
    else if (pcEnable) pc <= pc + 16'd1;
  end

  assign memData = mem[memAddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // driver: inputs change at the falling edge, outputs sampled 1 time unit later
  task automatic step(input logic mr, input logic ir, input logic fl, input logic rs,
                      input logic ld, input logic [15:0] ldv);
    @(negedge clk);
    memReady = mr; instrReady = ir; flush = fl; reset = rs;
    pc_load = ld; load_pc = ldv;
    #1;
  endtask

  task automatic do_reset(input logic [15:0] start);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, start);
    check("rst_memread", {31'd0, memRead}, 32'd0);
    check("rst_pcen", {31'd0, pcEnable}, 32'd0);
  endtask

  function automatic logic [1:0] ref_len(input logic [7:0] op);
    if (op < 8'h40) return 2'd1;
    else if (op < 8'h80) return 2'd2;
    else return 2'd3;
  endfunction

  typedef struct {
    logic        mr, ir, fl;
    logic        e_pcen, e_rd, e_valid;
    logic [15:0] e_pc;
    logic [7:0]  e_op;
    logic [15:0] e_operand;
    logic [1:0]  e_len;
  } vec_t;

  vec_t vecs[7];

  // scoreboard state for the random run
  logic [15:0] exp_q[$];
  logic [15:0] exp_addr;
  int          n_xfer;

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

    // ---- table-driven: 2-byte instruction at 0x0010 with waits
    mem[16'h0010] = 8'h45; mem[16'h0011] = 8'hAA;
    vecs[0] = '{1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 16'h0010, 8'h00, 16'h0000, 2'd0};
    vecs[1] = '{1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0, 16'h0010, 8'h00, 16'h0000, 2'd0};
    vecs[2] = '{1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 16'h0011, 8'h45, 16'h0000, 2'd2};
    vecs[3] = '{1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0, 16'h0011, 8'h45, 16'h0000, 2'd2};
    vecs[4] = '{1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1, 16'h0012, 8'h45, 16'h00AA, 2'd2};
    vecs[5] = '{1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1, 16'h0012, 8'h45, 16'h00AA, 2'd2};
    vecs[6] = '{1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 16'h0012, 8'h45, 16'h00AA, 2'd2};
    do_reset(16'h0010);
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].mr, vecs[i].ir, vecs[i].fl, 1'b1, 1'b0, 16'h0);
      check($sformatf("vec%0d_pcen", i), {31'd0, pcEnable}, {31'd0, vecs[i].e_pcen});
      check($sformatf("vec%0d_rd", i), {31'd0, memRead}, {31'd0, vecs[i].e_rd});
      check($sformatf("vec%0d_valid", i), {31'd0, instrValid}, {31'd0, vecs[i].e_valid});
      check($sformatf("vec%0d_pc", i), {16'd0, memAddr}, {16'd0, vecs[i].e_pc});
      check($sformatf("vec%0d_op", i), {24'd0, opcode}, {24'd0, vecs[i].e_op});
      check($sformatf("vec%0d_operand", i), {16'd0, operand}, {16'd0, vecs[i].e_operand});
      check($sformatf("vec%0d_len", i), {30'd0, instrLen}, {30'd0, vecs[i].e_len});
    end

    // ---- 1-byte zero-wait fetch at 0x0000, decoder always ready
    mem[16'h0000] = 8'h05;
    do_reset(16'h0000);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    check("b1_state_after_rst", {30'd0, dbg_state}, 32'd0);
    check("b1_len_after_rst", {30'd0, instrLen}, 32'd0);
    check("b1_valid_after_rst", {31'd0, instrValid}, 32'd0);
    check("b1_pcen", {31'd0, pcEnable}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    check("b1_valid", {31'd0, instrValid}, 32'd1);
    check("b1_opcode", {24'd0, opcode}, 32'h05);
    check("b1_len", {30'd0, instrLen}, 32'd1);
    check("b1_operand", {16'd0, operand}, 32'h0);
    check("b1_hold_pcen", {31'd0, pcEnable}, 32'd0);
    check("b1_hold_rd", {31'd0, memRead}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    check("b1_valid_drop", {31'd0, instrValid}, 32'd0);
    check("b1_next_rd", {31'd0, memRead}, 32'd1);
    check("b1_next_addr", {16'd0, memAddr}, 32'h0001);

    // ---- 3-byte at 0x00F0, 4 wait cycles in FETCH_B1, then 5 cycles backpressure
    mem[16'h00F0] = 8'h80; mem[16'h00F1] = 8'h34; mem[16'h00F2] = 8'h12;
    do_reset(16'h00F0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    check("b3_pcen0", {31'd0, pcEnable}, 32'd1);
    for (int w = 0; w < 4; w++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      check("b3_wait_rd", {31'd0, memRead}, 32'd1);
      check("b3_wait_addr", {16'd0, memAddr}, 32'h00F1);
      check("b3_wait_pcen", {31'd0, pcEnable}, 32'd0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    check("b3_pcen1", {31'd0, pcEnable}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    check("b3_pcen2", {31'd0, pcEnable}, 32'd1);
    check("b3_addr2", {16'd0, memAddr}, 32'h00F2);
    for (int h = 0; h < 5; h++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      check("b3_hold_valid", {31'd0, instrValid}, 32'd1);
      check("b3_hold_opcode", {24'd0, opcode}, 32'h80);
      check("b3_hold_operand", {16'd0, operand}, 32'h1234);
      check("b3_hold_len", {30'd0, instrLen}, 32'd3);
      check("b3_hold_rd", {31'd0, memRead}, 32'd0);
      check("b3_hold_pc", {16'd0, pc}, 32'h00F3);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    check("b3_after_valid", {31'd0, instrValid}, 32'd0);
    check("b3_after_pc", {16'd0, pc}, 32'h00F3);

    // ---- wrap-around: 3-byte at 0xFFFE, zero wait
    mem[16'hFFFE] = 8'hC1; mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h33;
    do_reset(16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
      check("wrap_pcen", {31'd0, pcEnable}, 32'd1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    check("wrap_valid", {31'd0, instrValid}, 32'd1);
    check("wrap_operand", {16'd0, operand}, 32'h3322);
    check("wrap_pc", {16'd0, pc}, 32'h0001);

    // ---- flush in FETCH_B1 of a 2-byte instruction, PC loaded to 0x0100
    mem[16'h0200] = 8'h40; mem[16'h0201] = 8'h99; mem[16'h0100] = 8'h07;
    do_reset(16'h0200);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0100);
    check("fl_pcen", {31'd0, pcEnable}, 32'd0);
    check("fl_rd", {31'd0, memRead}, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    check("fl_valid", {31'd0, instrValid}, 32'd0);
    check("fl_addr", {16'd0, memAddr}, 32'h0100);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    check("fl_new_valid", {31'd0, instrValid}, 32'd1);
    check("fl_new_op", {24'd0, opcode}, 32'h07);
    check("fl_new_len", {30'd0, instrLen}, 32'd1);

    // ---- reset mid-FETCH_B2, then flush with instrReady in HOLD
    mem[16'h0300] = 8'h81; mem[16'h0301] = 8'h11; mem[16'h0302] = 8'h01;
    do_reset(16'h0300);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    check("rb2_pcen", {31'd0, pcEnable}, 32'd0);
    check("rb2_rd", {31'd0, memRead}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    check("rb2_op", {24'd0, opcode}, 32'h0);
    check("rb2_operand", {16'd0, operand}, 32'h0);
    check("rb2_len", {30'd0, instrLen}, 32'd0);
    check("rb2_valid", {31'd0, instrValid}, 32'd0);
    check("rb2_pc", {16'd0, pc}, 32'h0302);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0400);
    check("rfl_valid_before", {31'd0, instrValid}, 32'd1);
    check("rfl_pcen", {31'd0, pcEnable}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    check("rfl_valid_after", {31'd0, instrValid}, 32'd0);
    check("rfl_addr", {16'd0, memAddr}, 32'h0400);
    check("rfl_rd", {31'd0, memRead}, 32'd1);

    // ---- randomized run against an instruction-stream model
    exp_addr = 16'($urandom);
    do_reset(exp_addr);
    n_xfer = 0;
    for (int c = 0; c < 4000; c++) begin
      logic        mr, ir, fl;
      logic [15:0] ldv;
      mr  = ($urandom_range(0, 3) != 0);
      ir  = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 39) == 0);
      ldv = 16'($urandom);
      step(mr, ir, fl, 1'b1, fl, ldv);
      if (memAddr !== pc) check("rnd_addr", {16'd0, memAddr}, {16'd0, pc});
      if (instrValid && memRead) check("rnd_rd_in_hold", {31'd0, memRead}, 32'd0);
      if (instrValid && ir && !fl) begin
        logic [7:0]  e_op;
        logic [1:0]  e_len;
        logic [15:0] e_opnd;
        e_op   = mem[exp_addr];
        e_len  = ref_len(e_op);
        e_opnd = 16'h0;
        if (e_len >= 2'd2) e_opnd[7:0] = mem[exp_addr + 16'd1];
        if (e_len == 2'd3) e_opnd[15:8] = mem[exp_addr + 16'd2];
        exp_q.push_back(exp_addr + 16'(e_len));
        check("rnd_opcode", {24'd0, opcode}, {24'd0, e_op});
        check("rnd_len", {30'd0, instrLen}, {30'd0, e_len});
        check("rnd_operand", {16'd0, operand}, {16'd0, e_opnd});
        check("rnd_pc", {16'd0, pc}, {16'd0, exp_q[$]});
        exp_addr = exp_q.pop_front();
        n_xfer++;
      end
      if (fl) exp_addr = ldv;
    end
    check("rnd_progress", {31'd0, (n_xfer > 100)}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

- Instruction fetch stage; consumer side of `programCounter`.
- Reads the byte-wide program memory at the current `pc` and assembles 1-, 2- or 3-byte instructions.
- Pulses the counter's `enable` once per byte consumed and presents complete instructions to the decoder over a valid/ready handshake.
- Sits between `programCounter` (and program memory) and the instruction decoder.

## Interface

Parameters:
- ADDR_W, 16, address width; matches `programCounter` width.
- DATA_W, 8, memory data width; opcode width.

Ports (clock and reset first):
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- pc  input  ADDR_W  current program counter value from `programCounter`.
- pcEnable  output  1  increment request; drives `programCounter.enable`.
- memAddr  output  ADDR_W  read address; combinationally equal to `pc`.
- memRead  output  1  read request to program memory.
- memData  input  DATA_W  read data; valid when `memRead` and `memReady` are both high.
- memReady  input  1  memory completes the read in this cycle.
- flush  input  1  branch/jump taken; discard everything in flight.
- instrValid  output  1  assembled instruction is available.
- instrReady  input  1  decoder accepts the instruction.
- opcode  output  DATA_W  first byte of the instruction.
- operand  output  2*DATA_W  `{byte2, byte1}` (little-endian); unused bytes are 0.
- instrLen  output  2  instruction length in bytes, 1..3.

## Operation

Length decode from `opcode[7:6]`:
- 00 -> 1 byte
- 01 -> 2 bytes
- 10 or 11 -> 3 bytes

States:
- FETCH_OP: `memRead`=1. On `memReady`: latch `opcode`, clear `operand`, set `instrLen`. Next state is FETCH_B1 if length > 1, otherwise HOLD.
- FETCH_B1: `memRead`=1. On `memReady`: latch `operand[7:0]`. Next state is FETCH_B2 if length = 3, otherwise HOLD.
- FETCH_B2: `memRead`=1. On `memReady`: latch `operand[15:8]`. Next state is HOLD.
- HOLD: `instrValid`=1 and `memRead`=0. `opcode`, `operand` and `instrLen` stay stable. On `instrReady`, go to FETCH_OP.

PC and memory rules:
- `pcEnable` = `memRead` & `memReady` & ~`flush`. It is combinational and lasts exactly one cycle per byte accepted.
- `programCounter` increments on that same edge, so the next cycle already sees `pc`+1.
- `memReady` low holds the current state, with `memRead` kept high and the address unchanged. The number of wait cycles is unlimited.
- Wrap-around: the PC wraps 16'hFFFF -> 16'h0000 by itself. The fetch unit needs no special case; a 3-byte instruction at 16'hFFFE reads FFFE, FFFF, 0000.

Flush and reset:
- `flush` (highest priority below reset), in any state:
  - next state is FETCH_OP;
  - `instrValid` goes 0 next cycle;
  - any partially assembled bytes are discarded;
  - `pcEnable` is forced 0 in the flush cycle, so a byte returned in that cycle is dropped and the PC is not advanced;
  - `memRead` is forced 0 in the flush cycle.
- The branch logic loads the new `pc` via `programCounter.load` in the same cycle as `flush`.
- Flush together with `instrReady` in HOLD: flush wins and the instruction counts as not consumed.
- Reset (`reset`=0 at a rising edge) gives:
  - state FETCH_OP;
  - `instrValid`=0;
  - `opcode`=0, `operand`=0, `instrLen`=0.
- `memRead` and `pcEnable` are 0 while `reset` is low.
- Reset mid-instruction abandons the partial instruction. No byte is consumed in the reset cycle.

## Timing

- Zero-wait memory, 1-byte instruction: opcode accepted at edge N; `instrValid` high from cycle N+1.
- 3-byte instruction: `instrValid` is high 3 cycles after the first `memRead` cycle.
- Handshake:
  - transfer occurs on the edge where `instrValid` & `instrReady` are both high;
  - `instrValid` drops the following cycle;
  - the next opcode read starts that same cycle.
- Throughput: 1-byte instructions with a decoder that is always ready complete one every 2 cycles.
- `instrReady` is ignored outside HOLD.
- `memAddr` has 0-cycle latency from `pc` (purely combinational).

## Test plan

- Reset, then `pc`=16'h0000, memory returns 8'h05 with zero wait, `instrReady`=1 -> exactly one `pcEnable` pulse; `instrValid` for one cycle with `opcode`=8'h05, `instrLen`=1, `operand`=16'h0000; next read at 16'h0001.
- 3-byte fetch: bytes 8'h80, 8'h34, 8'h12 starting at 16'h00F0 -> three `pcEnable` pulses; `operand`=16'h1234, `instrLen`=3; `pc` ends at 16'h00F3.
- `memReady` held low 4 cycles during FETCH_B1 -> `memRead` stays high with `memAddr` unchanged; no `pcEnable` until `memReady`; the result is identical to the zero-wait case.
- Backpressure: `instrReady`=0 for 5 cycles in HOLD -> `instrValid` stays 1, outputs stable, `memRead`=0, `pc` frozen.
- `flush` during FETCH_B1 of a 2-byte instruction with `memReady`=1, plus PC load to 16'h0100 -> no `pcEnable` that cycle; no `instrValid`; the next opcode is read from 16'h0100.
- `reset` low mid-FETCH_B2, then `flush` in HOLD together with `instrReady` -> all outputs return to reset values; the flushed instruction is never reported as transferred.
